// File: rtl/serial_operand_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_operand_driver_pkg
// Description : Shared state encoding and counter sizing for serial_operand_driver.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_operand_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Counter must reach WIDTH+RET_LAT-1; one extra code keeps clog2 safe for small sums.
  function automatic int cnt_width(input int width, input int ret_lat);
    return $clog2(width + ret_lat + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_operand_driver_piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_reg
// Description : Parallel-load register shifted out LSB first, zero-filling from the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clock) begin
    if (clear_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {1'b0, data_q[WIDTH-1:1]};
    end
  end

  assign bit_o = data_q[0];

endmodule
`default_nettype wire

// File: rtl/serial_operand_driver.sv
`default_nettype none
// ============================================================================
// Module      : serial_operand_driver
// Description : Drives two operands bit-serially into an adder and collects the
//               returned serial sum and final carry. Optional macro SELF_CHECK_EN
//               adds a reference adder that flags disagreement on mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_operand_driver
  import serial_operand_driver_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int RET_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             shift_cont,
  output logic             s_a,
  output logic             s_b,
  input  logic             sum_in,
  input  logic             carry_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             mismatch
);

  localparam int               CNT_W    = cnt_width(WIDTH, RET_LAT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH + RET_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             res_valid_q, res_valid_d;
  logic             shift_cont_q, shift_cont_d;
  logic             load_op, shift_op, last_cyc, capture_en;
  logic [WIDTH-1:0] collected;

  assign last_cyc  = (cnt_q == LAST_CNT);
  assign collected = {sum_in, result_q[WIDTH-1:1]};

  // The first RET_LAT shift cycles carry no returned sum bit yet.
  generate
    if (RET_LAT == 0) begin : g_cap_always
      assign capture_en = 1'b1;
    end else begin : g_cap_delayed
      assign capture_en = (cnt_q >= CNT_W'(RET_LAT));
    end
  endgenerate

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso_a (
    .clock   (clock),
    .clear_i (~reset),
    .load_i  (load_op),
    .shift_i (shift_op),
    .data_i  (a_in),
    .bit_o   (s_a)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso_b (
    .clock   (clock),
    .clear_i (~reset),
    .load_i  (load_op),
    .shift_i (shift_op),
    .data_i  (b_in),
    .bit_o   (s_b)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    carry_d      = carry_q;
    res_valid_d  = res_valid_q;
    shift_cont_d = 1'b0;
    load_op      = 1'b0;
    shift_op     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load_op      = 1'b1;
          cnt_d        = '0;
          result_d     = '0;
          carry_d      = 1'b0;
          shift_cont_d = 1'b1;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_op     = 1'b1;
        shift_cont_d = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (capture_en) begin
          result_d = collected;
        end
        if (last_cyc) begin
          carry_d      = carry_in;
          res_valid_d  = 1'b1;
          shift_cont_d = 1'b0;
          cnt_d        = '0;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      shift_cont_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      res_valid_q  <= res_valid_d;
      shift_cont_q <= shift_cont_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign shift_cont = shift_cont_q;
  assign res_valid  = res_valid_q;
  assign result     = result_q;
  assign carry_out  = carry_q;

`ifdef SELF_CHECK_EN
  logic [WIDTH:0] ref_q;
  logic           mismatch_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ref_q      <= '0;
      mismatch_q <= 1'b0;
    end else if (load_op) begin
      ref_q      <= {1'b0, a_in} + {1'b0, b_in};
      mismatch_q <= 1'b0;
    end else if ((state_q == ST_SHIFT) && last_cyc) begin
      mismatch_q <= ({carry_in, collected} != ref_q);
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_operand_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_operand_driver
// Description : Directed bench with a behavioural serial adder (one-cycle return)
//               in loopback and a queue of expected {carry, result} words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_operand_driver;

  localparam int WIDTH   = 4;
  localparam int RET_LAT = 1;

  logic clock = 1'b0;
  logic reset, in_valid, in_ready, shift_cont, s_a, s_b, sum_in, carry_in;
  logic res_valid, res_ready, carry_out, mismatch;
  logic [WIDTH-1:0] a_in, b_in, result;

  int vectors     = 0;
  int miscompares = 0;
  logic [WIDTH:0] sb[$];

  // Loopback adder; corrupt flips sum bit 2 to provoke the self-check.
  logic m_sum, m_carry, corrupt;
  int   m_pos;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!shift_cont) begin
      m_sum   <= 1'b0;
      m_carry <= 1'b0;
      m_pos   <= 0;
    end else begin
      m_sum   <= s_a ^ s_b ^ m_carry ^ (corrupt && (m_pos == 2));
      m_carry <= (s_a & s_b) | (s_a & m_carry) | (s_b & m_carry);
      m_pos   <= m_pos + 1;
    end
  end

  assign sum_in   = m_sum;
  assign carry_in = m_carry;

  serial_operand_driver #(.WIDTH(WIDTH), .RET_LAT(RET_LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .shift_cont (shift_cont),
    .s_a        (s_a),
    .s_b        (s_b),
    .sum_in     (sum_in),
    .carry_in   (carry_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .carry_out  (carry_out),
    .mismatch   (mismatch)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit bad,
                        input bit poke, input int hold_cycles);
    logic [WIDTH:0] exp;
    logic [7:0]     sa_seq, sb_seq;
    int             cyc, sc_cnt;
    exp = {1'b0, a} + {1'b0, b};
    if (bad) exp[2] = ~exp[2];
    sb.push_back(exp);
    @(negedge clock);
    in_valid = 1'b1; a_in = a; b_in = b; corrupt = bad; res_ready = 1'b0;
    chk("in_ready_idle", {7'd0, in_ready}, 8'd1);
    @(negedge clock);
    in_valid = 1'b0;
    cyc = 0; sc_cnt = 0; sa_seq = '0; sb_seq = '0;
    while (!res_valid && cyc < 20) begin
      if (shift_cont) sc_cnt++;
      if (cyc < 8) begin
        sa_seq[cyc] = s_a;
        sb_seq[cyc] = s_b;
      end
      if (poke) begin
        in_valid = cyc[0];
        a_in     = 4'hA;
      end
      cyc++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("res_valid_latency", 8'(cyc), 8'(WIDTH + RET_LAT));
    chk("shift_cont_cycles", 8'(sc_cnt), 8'(WIDTH + RET_LAT));
    chk("s_a_sequence", sa_seq, {4'd0, a});
    chk("s_b_sequence", sb_seq, {4'd0, b});
    for (int i = 0; i < hold_cycles; i++) begin
      chk("hold_result", {4'd0, result}, {4'd0, exp[3:0]});
      chk("hold_res_valid", {7'd0, res_valid}, 8'd1);
      chk("hold_in_ready", {7'd0, in_ready}, 8'd0);
      chk("hold_shift_cont", {7'd0, shift_cont}, 8'd0);
      @(negedge clock);
    end
    res_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      exp = sb.pop_front();
      chk("result", {4'd0, result}, {4'd0, exp[3:0]});
      chk("carry_out", {7'd0, carry_out}, {7'd0, exp[4]});
`ifdef SELF_CHECK_EN
      chk("mismatch", {7'd0, mismatch}, {7'd0, bad});
`else
      chk("mismatch", {7'd0, mismatch}, 8'd0);
`endif
      chk("in_ready_before_accept", {7'd0, in_ready}, 8'd0);
    end
    @(negedge clock);
    res_ready = 1'b0;
    corrupt   = 1'b0;
    chk("res_valid_cleared", {7'd0, res_valid}, 8'd0);
    chk("in_ready_after_accept", {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; res_ready = 1'b0; corrupt = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_shift_cont", {7'd0, shift_cont}, 8'd0);
    chk("rst_s_a_s_b", {6'd0, s_a, s_b}, 8'd0);
    chk("rst_res_valid", {7'd0, res_valid}, 8'd0);
    chk("rst_result", {3'd0, carry_out, result}, 8'd0);
    chk("rst_mismatch", {7'd0, mismatch}, 8'd0);
    reset = 1'b1;

    run_op(4'h3, 4'h5, 1'b0, 1'b0, 0);
    run_op(4'hF, 4'h1, 1'b0, 1'b0, 0);
    run_op(4'h7, 4'h9, 1'b0, 1'b0, 10);
    run_op(4'h2, 4'h3, 1'b0, 1'b1, 0);

    // Abort on shift cycle 2.
    @(negedge clock);
    in_valid = 1'b1; a_in = 4'hB; b_in = 4'h4;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_in_shift", {7'd0, shift_cont}, 8'd1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("abort_in_ready", {7'd0, in_ready}, 8'd1);
    chk("abort_shift_cont", {7'd0, shift_cont}, 8'd0);
    chk("abort_res_valid", {7'd0, res_valid}, 8'd0);
    chk("abort_s_a_s_b", {6'd0, s_a, s_b}, 8'd0);
    chk("abort_result", {3'd0, carry_out, result}, 8'd0);

    run_op(4'hC, 4'h6, 1'b0, 1'b0, 0);
`ifdef SELF_CHECK_EN
    run_op(4'h5, 4'h6, 1'b1, 1'b0, 2);
`endif
    run_op(4'h5, 4'h6, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
